imu_stream_arbiter: RTL and testbench

IMU_STREAM_ARBITER -- requirements
Module: imu_stream_arbiter

---
 rtl/imu_pkg.sv | 27 ++
 rtl/imu_stream_arbiter_if.sv | 30 +++
 rtl/imu_chan_buffer.sv | 77 +++++++
 rtl/imu_stream_arbiter.sv | 91 +++++++++
 tb/tb_imu_stream_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imu_pkg.sv
// IMU stream arbiter shared types: sample payload, FSM state encoding, defaults.
package imu_pkg;

    localparam int unsigned IMU_NUM_CH = 2;
    localparam int unsigned IMU_AXIS_W = 16;
    localparam int unsigned IMU_WD_W   = 24;

    localparam logic [IMU_WD_W-1:0] IMU_TIMEOUT_DEFAULT = 24'd1_000_000;

    typedef struct packed {
        logic signed [IMU_AXIS_W-1:0] quat_w;
        logic signed [IMU_AXIS_W-1:0] quat_x;
        logic signed [IMU_AXIS_W-1:0] quat_y;
        logic signed [IMU_AXIS_W-1:0] quat_z;
        logic signed [IMU_AXIS_W-1:0] gyro_x;
        logic signed [IMU_AXIS_W-1:0] gyro_y;
        logic signed [IMU_AXIS_W-1:0] gyro_z;
        logic                         quat_valid;
        logic                         gyro_valid;
    } imu_sample_t;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_PRESENT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/imu_stream_arbiter_if.sv
// Stream bus of the IMU arbiter: two producer strobes in, one handshaked output.
interface imu_stream_arbiter_if;
    import imu_pkg::*;

    logic        [IMU_NUM_CH-1:0] in_valid;
    imu_sample_t [IMU_NUM_CH-1:0] in_sample;
    logic                         out_valid;
    logic                         out_ready;
    imu_sample_t                  out_sample;
    logic                         out_ch;

    modport slave (
        input  in_valid,
        input  in_sample,
        input  out_ready,
        output out_valid,
        output out_sample,
        output out_ch
    );

    modport master (
        output in_valid,
        output in_sample,
        output out_ready,
        input  out_valid,
        input  out_sample,
        input  out_ch
    );

endinterface

// File: rtl/imu_chan_buffer.sv
// One IMU channel: single-entry newest-wins holding buffer, saturating overwrite
// counter and, when IMU_ARB_WATCHDOG_EN is defined, a stale-input watchdog.
module imu_chan_buffer
    import imu_pkg::*;
#(
    parameter logic [IMU_WD_W-1:0] TIMEOUT_CYCLES = IMU_TIMEOUT_DEFAULT,
    parameter int unsigned         DROP_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  imu_sample_t           in_sample,
    input  logic                  take_c,
    output logic                  full,
    output imu_sample_t           data,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  stale
);

    localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

    // A new sample replaces an unconsumed one only if the arbiter is not taking it now.
    logic overwrite_c;
    assign overwrite_c = in_valid && full && !take_c;

    // Holding buffer and overwrite counter; a strobe on the take edge refills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            data     <= '0;
            drop_cnt <= '0;
        end else begin
            if (in_valid) begin
                data <= in_sample;
            end
            if (in_valid) begin
                full <= 1'b1;
            end else if (take_c) begin
                full <= 1'b0;
            end
            if (overwrite_c && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

`ifdef IMU_ARB_WATCHDOG_EN
    logic [IMU_WD_W-1:0] wd_cnt;
    logic [IMU_WD_W-1:0] wd_cnt_d;

    // Idle-cycle count since the last strobe, saturating at the timeout.
    always_comb begin
        wd_cnt_d = wd_cnt;
        if (in_valid) begin
            wd_cnt_d = '0;
        end else if (wd_cnt != TIMEOUT_CYCLES) begin
            wd_cnt_d = wd_cnt + IMU_WD_W'(1);
        end
    end

    // Counter register with stale flag tracking counter==timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            stale  <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_d;
            stale  <= (wd_cnt_d == TIMEOUT_CYCLES);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign stale          = 1'b0;
`endif

endmodule

// File: rtl/imu_stream_arbiter.sv
// Two-channel IMU sample arbiter: per-channel newest-wins buffers feed a single
// registered output with valid/ready handshake and round-robin grant.
// Optional stale-channel watchdog enabled by defining IMU_ARB_WATCHDOG_EN.
module imu_stream_arbiter
    import imu_pkg::*;
#(
    parameter logic [IMU_WD_W-1:0] TIMEOUT_CYCLES = IMU_TIMEOUT_DEFAULT,
    parameter int unsigned         DROP_CNT_W     = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    imu_stream_arbiter_if.slave                   bus,
    output logic [IMU_NUM_CH-1:0][DROP_CNT_W-1:0] drop_cnt,
    output logic [IMU_NUM_CH-1:0]                 stale
);

    localparam logic [0:0] S_IDLE    = ARB_IDLE;
    localparam logic [0:0] S_PRESENT = ARB_PRESENT;

    logic        [IMU_NUM_CH-1:0] full;
    imu_sample_t [IMU_NUM_CH-1:0] buf_data;
    logic        [IMU_NUM_CH-1:0] take_c;

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       last_q;
    logic       load_c;
    logic       win_c;

    for (genvar g = 0; g < IMU_NUM_CH; g++) begin : g_ch
        imu_chan_buffer #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .DROP_CNT_W     (DROP_CNT_W)
        ) u_buf (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (bus.in_valid[g]),
            .in_sample (bus.in_sample[g]),
            .take_c    (take_c[g]),
            .full      (full[g]),
            .data      (buf_data[g]),
            .drop_cnt  (drop_cnt[g]),
            .stale     (stale[g])
        );
    end

    // Next state and grant: round-robin when both pending, else the pending one.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        take_c  = '0;
        win_c   = (full == 2'b11) ? ~last_q : full[1];
        case (state_q)
            S_IDLE: begin
                if (|full) begin
                    load_c        = 1'b1;
                    take_c[win_c] = 1'b1;
                    state_d       = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (bus.out_valid && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, last-grant and output registers; output holds until handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            last_q         <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.out_sample <= '0;
            bus.out_ch     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_c) begin
                last_q         <= win_c;
                bus.out_valid  <= 1'b1;
                bus.out_sample <= buf_data[win_c];
                bus.out_ch     <= win_c;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imu_stream_arbiter.sv
// Self-checking bench for imu_stream_arbiter: vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_imu_stream_arbiter;
    import imu_pkg::*;

    localparam int unsigned DW    = 3;
    localparam logic [23:0] TMO   = 24'd100;
    localparam int          TMO_I = 100;
    localparam int          DMAX  = (1 << DW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0][DW-1:0] drop_cnt;
    logic [1:0]         stale;

    int checks = 0;
    int errors = 0;

    imu_stream_arbiter_if bus();

    imu_stream_arbiter #(
        .TIMEOUT_CYCLES (TMO),
        .DROP_CNT_W     (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .drop_cnt (drop_cnt),
        .stale    (stale)
    );

    always #5 clk = ~clk;

    // Reference model: pending sample per channel, one presented sample.
    logic        m_ov, m_ch, m_last;
    imu_sample_t m_out;
    logic        m_full [2];
    imu_sample_t m_buf  [2];
    int          m_drop [2];
    int          m_wd   [2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic imu_sample_t mk(input logic [15:0] qx, input logic [15:0] gz);
        imu_sample_t s;
        s.quat_w     = 16'sh4000;
        s.quat_x     = qx;
        s.quat_y     = -16'sd1;
        s.quat_z     = 16'sh8000;
        s.gyro_x     = 16'sh0123;
        s.gyro_y     = 16'shFEDC;
        s.gyro_z     = gz;
        s.quat_valid = 1'b1;
        s.gyro_valid = 1'b0;
        return s;
    endfunction

    function automatic imu_sample_t rnd_sample();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[113:0];
    endfunction

    task automatic model_reset();
        m_ov = 1'b0; m_ch = 1'b0; m_last = 1'b1; m_out = '0;
        for (int c = 0; c < 2; c++) begin
            m_full[c] = 1'b0; m_buf[c] = '0; m_drop[c] = 0; m_wd[c] = 0;
        end
    endtask

    task automatic model_edge(input logic [1:0] iv, input imu_sample_t s0,
                              input imu_sample_t s1, input logic rdy);
        imu_sample_t s [2];
        int pick;
        s[0] = s0;
        s[1] = s1;
        if (m_ov) begin
            if (rdy) m_ov = 1'b0;
        end else if (m_full[0] || m_full[1]) begin
            if (m_full[0] && m_full[1]) pick = m_last ? 0 : 1;
            else                        pick = m_full[0] ? 0 : 1;
            m_out        = m_buf[pick];
            m_ch         = (pick == 1);
            m_last       = (pick == 1);
            m_ov         = 1'b1;
            m_full[pick] = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            if (iv[c]) begin
                if (m_full[c] && m_drop[c] < DMAX) m_drop[c]++;
                m_buf[c]  = s[c];
                m_full[c] = 1'b1;
                m_wd[c]   = 0;
            end else if (m_wd[c] < TMO_I) begin
                m_wd[c]++;
            end
        end
    endtask

    task automatic cmp_model();
        logic [1:0] exp_stale;
`ifdef IMU_ARB_WATCHDOG_EN
        exp_stale = {m_wd[1] == TMO_I, m_wd[0] == TMO_I};
`else
        exp_stale = 2'b00;
`endif
        chk("rnd_valid",  128'(bus.out_valid),  128'(m_ov));
        chk("rnd_ch",     128'(bus.out_ch),     128'(m_ch));
        chk("rnd_sample", 128'(bus.out_sample), 128'(m_out));
        chk("rnd_drop0",  128'(drop_cnt[0]),    128'(m_drop[0]));
        chk("rnd_drop1",  128'(drop_cnt[1]),    128'(m_drop[1]));
        chk("rnd_stale",  128'(stale),          128'(exp_stale));
    endtask

    // Apply inputs for one edge, advance the model, sample 1ns after the edge.
    task automatic tick(input logic [1:0] iv, input imu_sample_t s0,
                        input imu_sample_t s1, input logic rdy);
        bus.in_valid     = iv;
        bus.in_sample[0] = s0;
        bus.in_sample[1] = s1;
        bus.out_ready    = rdy;
        @(posedge clk);
        model_edge(iv, s0, s1, rdy);
        #1;
    endtask

    task automatic idle(input logic rdy);
        tick(2'b00, '0, '0, rdy);
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset(input string tag);
        bus.in_valid  = 2'b00;
        bus.in_sample = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_valid"},  128'(bus.out_valid),  128'(0));
        chk({tag, "_rst_sample"}, 128'(bus.out_sample), 128'(0));
        chk({tag, "_rst_ch"},     128'(bus.out_ch),     128'(0));
        chk({tag, "_rst_drop"},   128'(drop_cnt),       128'(0));
        chk({tag, "_rst_stale"},  128'(stale),          128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [1:0]    iv;
        logic [15:0]   t0;
        logic [15:0]   t1;
        logic          rdy;
        logic          e_ov;
        logic          e_ch;
        logic [15:0]   e_tag;
        logic [DW-1:0] e_d0;
        logic [DW-1:0] e_d1;
    } vec_t;

    vec_t vt [23];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 2'b00;
        bus.in_sample = '0;
        bus.out_ready = 1'b0;
        model_reset();

        //          iv     t0       t1       rdy  ov  ch  tag      d0  d1
        vt[0]  = '{2'b11, 16'h000A, 16'h001A, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 3'd0};
        vt[1]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h000A, 3'd0, 3'd0};
        vt[2]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 3'd0};
        vt[3]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h001A, 3'd0, 3'd0};
        vt[4]  = '{2'b01, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 3'd0};
        vt[5]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234, 3'd0, 3'd0};
        vt[6]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 3'd0};
        vt[7]  = '{2'b11, 16'h000C, 16'h001C, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 3'd0};
        vt[8]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h001C, 3'd0, 3'd0};
        vt[9]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 3'd0};
        vt[10] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h000C, 3'd0, 3'd0};
        vt[11] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h000C, 3'd0, 3'd0};
        vt[12] = '{2'b10, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h000C, 3'd0, 3'd0};
        vt[13] = '{2'b10, 16'h0000, 16'h0002, 1'b0, 1'b1, 1'b0, 16'h000C, 3'd0, 3'd1};
        vt[14] = '{2'b10, 16'h0000, 16'h0003, 1'b0, 1'b1, 1'b0, 16'h000C, 3'd0, 3'd2};
        vt[15] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 3'd2};
        vt[16] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0003, 3'd0, 3'd2};
        vt[17] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 3'd2};
        vt[18] = '{2'b01, 16'h0055, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 3'd2};
        vt[19] = '{2'b01, 16'h0066, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0055, 3'd0, 3'd2};
        vt[20] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 3'd2};
        vt[21] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0066, 3'd0, 3'd2};
        vt[22] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 3'd2};

        // Vector table: contention, single packet, overwrite, same-edge refill.
        do_reset("tbl");
        for (int i = 0; i < 23; i++) begin
            logic [15:0] act_tag;
            tick(vt[i].iv, mk(vt[i].t0, 16'h0000), mk(16'h0000, vt[i].t1), vt[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 128'(bus.out_valid), 128'(vt[i].e_ov));
            if (vt[i].e_ov) begin
                act_tag = vt[i].e_ch ? bus.out_sample.gyro_z : bus.out_sample.quat_x;
                chk($sformatf("tbl%0d_ch", i),  128'(bus.out_ch), 128'(vt[i].e_ch));
                chk($sformatf("tbl%0d_tag", i), 128'(act_tag),    128'(vt[i].e_tag));
            end
            chk($sformatf("tbl%0d_drop0", i), 128'(drop_cnt[0]), 128'(vt[i].e_d0));
            chk($sformatf("tbl%0d_drop1", i), 128'(drop_cnt[1]), 128'(vt[i].e_d1));
            chk($sformatf("tbl%0d_stale", i), 128'(stale),       128'(0));
        end

        // Backpressure: presented sample frozen for 10 stalled cycles, one handshake.
        do_reset("bp");
        tick(2'b01, mk(16'h0077, 16'h0000), '0, 1'b0);
        chk("bp_not_yet", 128'(bus.out_valid), 128'(0));
        idle(1'b0);
        chk("bp_valid", 128'(bus.out_valid), 128'(1));
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            chk($sformatf("bp_hold%0d_valid", i),  128'(bus.out_valid),  128'(1));
            chk($sformatf("bp_hold%0d_ch", i),     128'(bus.out_ch),     128'(0));
            chk($sformatf("bp_hold%0d_sample", i), 128'(bus.out_sample), 128'(mk(16'h0077, 16'h0000)));
        end
        idle(1'b1);
        chk("bp_release", 128'(bus.out_valid), 128'(0));
        for (int i = 0; i < 2; i++) begin
            idle(1'b1);
            chk($sformatf("bp_after%0d", i), 128'(bus.out_valid), 128'(0));
        end

        // Reset during PRESENT with ch1 granted and a drop recorded.
        do_reset("mid");
        tick(2'b10, '0, mk(16'h0000, 16'h00A1), 1'b0);
        tick(2'b10, '0, mk(16'h0000, 16'h00B2), 1'b0);
        tick(2'b10, '0, mk(16'h0000, 16'h00C3), 1'b0);
        chk("mid_pre_valid", 128'(bus.out_valid), 128'(1));
        chk("mid_pre_ch",    128'(bus.out_ch),    128'(1));
        chk("mid_pre_drop1", 128'(drop_cnt[1]),   128'(1));
        do_reset("mid");
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            chk($sformatf("mid_quiet%0d", i), 128'(bus.out_valid), 128'(0));
        end
        tick(2'b01, mk(16'h0042, 16'h0000), '0, 1'b1);
        idle(1'b1);
        chk("mid_resume_valid", 128'(bus.out_valid),         128'(1));
        chk("mid_resume_ch",    128'(bus.out_ch),            128'(0));
        chk("mid_resume_qx",    128'(bus.out_sample.quat_x), 128'(16'h0042));

        // Watchdog: ch0 silent while ch1 keeps strobing.
        do_reset("wd");
`ifdef IMU_ARB_WATCHDOG_EN
        for (int i = 0; i < 99; i++) tick(2'b10, '0, mk(16'h0000, 16'(i)), 1'b1);
        chk("wd_99_stale", 128'(stale), 128'(2'b00));
        tick(2'b10, '0, mk(16'h0000, 16'h0063), 1'b1);
        chk("wd_100_stale", 128'(stale), 128'(2'b01));
        idle(1'b1);
        chk("wd_sat_stale", 128'(stale), 128'(2'b01));
        tick(2'b01, mk(16'h0001, 16'h0000), '0, 1'b1);
        chk("wd_clear_stale", 128'(stale), 128'(2'b00));
`else
        for (int i = 0; i < 120; i++) idle(1'b1);
        chk("wd_off_stale", 128'(stale), 128'(2'b00));
`endif

        // Randomized traffic against the reference model.
        do_reset("rnd");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [1:0] iv;
            logic       rdy;
            int         pv;
            int         pr;
            pv = (cyc < 1000) ? 60 : 30;
            pr = (cyc < 1000) ? 15 : 60;
            iv[0] = ($urandom_range(99) < pv);
            iv[1] = ($urandom_range(99) < pv) && !(cyc >= 2000 && cyc < 2200);
            rdy   = ($urandom_range(99) < pr);
            tick(iv, rnd_sample(), rnd_sample(), rdy);
            cmp_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
